// File: rtl/sieve_sequencer.sv
// Sequences an Eratosthenes sieve over an external 1-bit dual-port RAM (1 = composite):
// clear the RAM, mark the composites, then step through the primes one per tick.
module sieve_sequencer #(
   parameter int unsigned N      = 999999,
   parameter int unsigned AW     = 20,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rstn_signal,
   input  logic          start,
   input  logic          select,
   input  logic          tick,
   output logic          ram_wea,
   output logic [AW-1:0] ram_waddr,
   output logic          ram_wdata,
   output logic [AW-1:0] ram_raddr,
   input  logic          ram_rdata,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] prime_out,
   output logic          prime_valid,
   output logic [2:0]    dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_OUT_RD  = 3'd2,
      S_MARK    = 3'd3,
      S_SCAN_RD = 3'd4,
      S_HOLD    = 3'd5,
      S_DONE    = 3'd6
   } state_e;

   // Scan and mark addresses carry one extra bit so stepping past N never wraps.
   localparam logic [AW:0]     N_W  = (AW+1)'(N);
   localparam logic [2*AW-1:0] N_P  = (2*AW)'(N);
   localparam logic [2:0]      LAT  = 3'(RD_LAT);
   localparam logic [AW:0]     TWO  = (AW+1)'(2);
   localparam logic [AW:0]     ONE  = (AW+1)'(1);

   state_e        state_q, state_d;
   logic [AW-1:0] i_q, i_d;
   logic [AW:0]   j_q, j_d;
   logic [AW:0]   a_q, a_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic [AW-1:0] prime_q, prime_d;
   logic          pv_q, pv_d;

   logic [2*AW-1:0] sq;
   logic            rd_ok;
   logic            scan_end;
   logic [AW:0]     a_first;
   logic [AW:0]     a_step;

   assign sq       = {{AW{1'b0}}, i_q} * {{AW{1'b0}}, i_q};
   assign rd_ok    = (cnt_q == LAT);
   assign scan_end = dir_q ? (a_q > N_W) : (a_q < TWO);
   assign a_first  = dir_q ? TWO : N_W;
   assign a_step   = dir_q ? (a_q + ONE) : (a_q - ONE);

   always_ff @(posedge clk or negedge rstn_signal) begin
      if (!rstn_signal) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         prime_q <= '0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         prime_q <= prime_d;
         pv_q    <= pv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      prime_d = prime_q;
      pv_d    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CLEAR;
               j_d     = '0;
               dir_d   = select;
            end
         end
         S_CLEAR: begin
            if (j_q == N_W) begin
               state_d = S_OUT_RD;
               i_d     = AW'(2);
               cnt_d   = '0;
            end else begin
               j_d = j_q + ONE;
            end
         end
         S_OUT_RD: begin
            if (sq > N_P) begin
               state_d = S_SCAN_RD;
               a_d     = a_first;
               cnt_d   = '0;
            end else if (rd_ok) begin
               cnt_d = '0;
               if (!ram_rdata) begin
                  state_d = S_MARK;
                  j_d     = sq[AW:0];
               end else begin
                  i_d = i_q + AW'(1);
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_MARK: begin
            if (j_q <= N_W) begin
               j_d = j_q + {1'b0, i_q};
            end else begin
               state_d = S_OUT_RD;
               i_d     = i_q + AW'(1);
               cnt_d   = '0;
            end
         end
         S_SCAN_RD: begin
            if (scan_end) begin
               state_d = S_DONE;
            end else if (rd_ok) begin
               cnt_d = '0;
               if (ram_rdata) a_d = a_step;
               else           state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_HOLD: begin
            if (tick) begin
               state_d = S_SCAN_RD;
               prime_d = a_q[AW-1:0];
               pv_d    = 1'b1;
               a_d     = a_step;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // RAM read address is only driven in the read states, so it never aliases a write.
   always_comb begin
      ram_wea     = 1'b0;
      ram_waddr   = '0;
      ram_wdata   = 1'b0;
      ram_raddr   = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_q)
         S_CLEAR: begin
            ram_wea   = 1'b1;
            ram_waddr = j_q[AW-1:0];
            busy      = 1'b1;
         end
         S_OUT_RD: begin
            ram_raddr = i_q;
            busy      = 1'b1;
         end
         S_MARK: begin
            ram_wea   = (j_q <= N_W);
            ram_waddr = j_q[AW-1:0];
            ram_wdata = 1'b1;
            busy      = 1'b1;
         end
         S_SCAN_RD: begin
            ram_raddr = a_q[AW-1:0];
            busy      = 1'b1;
         end
         S_HOLD:  busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign prime_out   = prime_q;
   assign prime_valid = pv_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sieve_sequencer.sv
// Bench for sieve_sequencer: several instances with their own RAM models, one run at a time,
// emitted primes checked against an expected queue built from a software primality model.
module tb_sieve_sequencer;

   localparam int AW = 5;
   localparam int NI = 6;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MARK = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd5;

   function automatic int cfg_n(input int g);
      case (g)
         3:       return 2;
         4:       return 4;
         5:       return 31;
         default: return 30;
      endcase
   endfunction

   function automatic int cfg_l(input int g);
      case (g)
         1:       return 1;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic bit is_prime(input int v);
      if (v < 2) return 0;
      for (int d = 2; d * d <= v; d++) if (v % d == 0) return 0;
      return 1;
   endfunction

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn;

   logic          start_s [NI];
   logic          sel_s   [NI];
   logic          tick_s  [NI];
   wire           wea_w   [NI];
   wire           wdata_w [NI];
   wire           busy_w  [NI];
   wire           done_w  [NI];
   wire           pv_w    [NI];
   wire  [AW-1:0] waddr_w [NI];
   wire  [AW-1:0] raddr_w [NI];
   wire  [AW-1:0] prime_w [NI];
   wire  [2:0]    st_w    [NI];

   logic [AW-1:0] exp_q[$];
   int checks;
   int errors;
   int emit_cnt [NI];

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int unsigned NN = cfg_n(g);
      localparam int unsigned RL = cfg_l(g);
      logic       mem [0:31];
      logic [7:0] pipe;
      logic       rdata;

      always @(posedge clk) begin
         if (wea_w[g]) mem[waddr_w[g]] <= wdata_w[g];
         pipe <= {pipe[6:0], mem[raddr_w[g]]};
      end
      assign rdata = pipe[RL-1];

      sieve_sequencer #(.N(NN), .AW(AW), .RD_LAT(RL)) u_dut (
         .clk         (clk),
         .rstn_signal (rstn),
         .start       (start_s[g]),
         .select      (sel_s[g]),
         .tick        (tick_s[g]),
         .ram_wea     (wea_w[g]),
         .ram_waddr   (waddr_w[g]),
         .ram_wdata   (wdata_w[g]),
         .ram_raddr   (raddr_w[g]),
         .ram_rdata   (rdata),
         .busy        (busy_w[g]),
         .done        (done_w[g]),
         .prime_out   (prime_w[g]),
         .prime_valid (pv_w[g]),
         .dbg_state_o (st_w[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard: every prime_valid pulse pops one expected prime
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (pv_w[k] === 1'b1) begin
            emit_cnt[k]++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_prime inst%0d: observed %0d expected none", k, prime_w[k]);
            end else begin
               check($sformatf("prime_inst%0d", k), 32'(prime_w[k]), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // driver tasks
   task automatic pulse_start(input int k);
      @(negedge clk);
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
   endtask

   task automatic push_primes(input int n, input logic asc, output int cnt, output int last);
      cnt  = 0;
      last = 0;
      if (asc) begin
         for (int v = 2; v <= n; v++) if (is_prime(v)) begin exp_q.push_back(AW'(v)); cnt++; last = v; end
      end else begin
         for (int v = n; v >= 2; v--) if (is_prime(v)) begin exp_q.push_back(AW'(v)); cnt++; last = v; end
      end
   endtask

   task automatic wait_done(input int k, input int budget, input string tag);
      int n;
      n = 0;
      while (done_w[k] !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(done_w[k]), 32'd1);
   endtask

   function automatic logic [31:0] out_vec(input int k);
      return 32'({wea_w[k], wdata_w[k], waddr_w[k], raddr_w[k], busy_w[k], done_w[k],
                  prime_w[k], pv_w[k]});
   endfunction

   task automatic full_run(input int k, input logic sel, input string tag);
      int n_exp, last, e0;
      push_primes(cfg_n(k), sel, n_exp, last);
      e0        = emit_cnt[k];
      sel_s[k]  = sel;
      tick_s[k] = 1'b1;
      pulse_start(k);
      check({tag, "_busy_after_start"}, 32'(busy_w[k]), 32'd1);
      wait_done(k, 3000, tag);
      repeat (2) @(negedge clk);
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_busy_end"}, 32'(busy_w[k]), 32'd0);
      check({tag, "_last_prime"}, 32'(prime_w[k]), 32'(last));
      check({tag, "_emissions"}, 32'(emit_cnt[k] - e0), 32'(n_exp));
      exp_q.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, entries, cnt, last;
      logic [2:0] prev;
      bit seen;

      rstn = 1'b0;
      for (int k = 0; k < NI; k++) begin
         start_s[k] = 1'b0;
         sel_s[k]   = 1'b1;
         tick_s[k]  = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) check($sformatf("reset_outs%0d", k), out_vec(k), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // ascending and descending full runs, N=30
      full_run(0, 1'b1, "asc30");
      full_run(0, 1'b0, "desc30");

      // tick stall, start/select ignored while busy, single-tick emission
      exp_q.push_back(AW'(2));
      e0        = emit_cnt[0];
      sel_s[0]  = 1'b1;
      tick_s[0] = 1'b1;
      pulse_start(0);
      seen = 0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (pv_w[0] === 1'b1) begin seen = 1; break; end
      end
      tick_s[0] = 1'b0;
      check("first_emit_seen", 32'(seen), 32'd1);
      repeat (20) @(negedge clk);
      check("stall_prime", 32'(prime_w[0]), 32'd2);
      check("stall_busy", 32'(busy_w[0]), 32'd1);
      check("stall_emissions", 32'(emit_cnt[0] - e0), 32'd1);
      check("stall_state", 32'(st_w[0]), 32'(ST_HOLD));
      sel_s[0] = 1'b0;
      pulse_start(0);
      repeat (5) @(negedge clk);
      check("busy_start_ignored_prime", 32'(prime_w[0]), 32'd2);
      check("busy_start_ignored_state", 32'(st_w[0]), 32'(ST_HOLD));
      exp_q.push_back(AW'(3));
      @(negedge clk);
      tick_s[0] = 1'b1;
      @(negedge clk);
      tick_s[0] = 1'b0;
      repeat (10) @(negedge clk);
      check("one_tick_emissions", 32'(emit_cnt[0] - e0), 32'd2);
      check("one_tick_prime", 32'(prime_w[0]), 32'd3);
      for (int v = 5; v <= 30; v++) if (is_prime(v)) exp_q.push_back(AW'(v));
      tick_s[0] = 1'b1;
      wait_done(0, 3000, "stall_run");
      repeat (2) @(negedge clk);
      check("stall_run_queue_left", 32'(exp_q.size()), 32'd0);
      check("stall_run_last_prime", 32'(prime_w[0]), 32'd29);
      exp_q.delete();

      // reset in the middle of marking multiples of 3
      sel_s[0] = 1'b1;
      pulse_start(0);
      entries = 0;
      prev    = st_w[0];
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (st_w[0] == ST_MARK && prev != ST_MARK) entries++;
         prev = st_w[0];
         if (entries == 2) break;
      end
      check("mark_i3_reached", 32'(entries), 32'd2);
      check("mark_i3_wea", 32'(wea_w[0]), 32'd1);
      rstn = 1'b0;
      #1;
      check("midrun_reset_outs", out_vec(0), 32'd0);
      check("midrun_reset_state", 32'(st_w[0]), 32'(ST_IDLE));
      @(negedge clk);
      rstn = 1'b1;
      full_run(0, 1'b1, "after_reset");

      // read latency variants and range edges
      full_run(1, 1'b1, "lat1");
      full_run(2, 1'b1, "lat3");
      full_run(3, 1'b1, "n2");
      full_run(4, 1'b1, "n4");
      full_run(5, 1'b1, "n31_asc");
      full_run(5, 1'b0, "n31_desc");
      push_primes(31, 1'b1, cnt, last);
      exp_q.delete();
      check("n31_model_count", 32'(cnt), 32'(emit_cnt[5] / 2));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
